// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 register/memory transfer sequencer.
package chip8_pkg;

    localparam int unsigned MEM_AW = 16;

    localparam logic [1:0] XFER_STORE = 2'd0;
    localparam logic [1:0] XFER_LOAD  = 2'd1;
    localparam logic [1:0] XFER_BCD   = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StStore,
        StLoad,
        StLdrain,
        StBcd,
        StFin
    } xfer_state_e;

endpackage

// File: rtl/bcd_digits.sv
// Combinational split of an 8-bit binary value into hundreds, tens and ones digits.
module bcd_digits (
    input  logic [7:0] bin_i,
    output logic [3:0] hund_o,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    always_comb begin
        hund_o = 4'(bin_i / 8'd100);
        tens_o = 4'((bin_i / 8'd10) % 8'd10);
        ones_o = 4'(bin_i % 8'd10);
    end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Sequencer for the CHIP-8 Fx55 / Fx65 / Fx33 bulk transfers between the
// register file and main memory. Outputs are decoded from registered state.
module reg_xfer_ctrl
    import chip8_pkg::*;
#(
    parameter bit INC_I = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [3:0]        i_x,
    output logic              o_busy,
    output logic              o_done,
    output logic [3:0]        o_vx_addr,
    input  logic [7:0]        i_vx_data,
    output logic              o_vx_en,
    output logic [7:0]        o_vx_data,
    input  logic [MEM_AW-1:0] i_i_rd,
    output logic              o_i_en,
    output logic [MEM_AW-1:0] o_i_data,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    output logic              o_mem_re,
    input  logic [7:0]        i_mem_rdata
);

    xfer_state_e       state_q;
    logic [1:0]        op_q;
    logic [3:0]        x_q;
    logic [3:0]        k_q;
    logic [MEM_AW-1:0] base_q;
    logic [7:0]        v_q;

    logic              k_last;
    logic [MEM_AW-1:0] k_addr;
    logic [7:0]        bcd_src;
    logic [3:0]        dig_hund;
    logic [3:0]        dig_tens;
    logic [3:0]        dig_ones;

    assign k_last = (k_q == x_q);
    assign k_addr = base_q + MEM_AW'(k_q);

    // First BCD cycle digitises the live read; later cycles use the held copy.
    assign bcd_src = (k_q == 4'd0) ? i_vx_data : v_q;

    bcd_digits u_bcd_digits (
        .bin_i  (bcd_src),
        .hund_o (dig_hund),
        .tens_o (dig_tens),
        .ones_o (dig_ones)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            x_q     <= '0;
            k_q     <= '0;
            base_q  <= '0;
            v_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        op_q   <= i_op;
                        x_q    <= i_x;
                        base_q <= i_i_rd;
                        k_q    <= '0;
                        case (i_op)
                            XFER_STORE: state_q <= StStore;
                            XFER_LOAD:  state_q <= StLoad;
                            XFER_BCD:   state_q <= StBcd;
                            default:    state_q <= StFin;
                        endcase
                    end
                end
                StStore: begin
                    k_q <= k_q + 4'd1;
                    if (k_last) state_q <= StFin;
                end
                StLoad: begin
                    k_q <= k_q + 4'd1;
                    if (k_last) state_q <= StLdrain;
                end
                StLdrain: state_q <= StFin;
                StBcd: begin
                    if (k_q == 4'd0) v_q <= i_vx_data;
                    k_q <= k_q + 4'd1;
                    if (k_q == 4'd2) state_q <= StFin;
                end
                StFin: begin
                    k_q     <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_busy      = (state_q != StIdle);
        o_done      = 1'b0;
        o_vx_addr   = '0;
        o_vx_en     = 1'b0;
        o_vx_data   = '0;
        o_i_en      = 1'b0;
        o_i_data    = '0;
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        o_mem_re    = 1'b0;
        case (state_q)
            StStore: begin
                o_vx_addr   = k_q;
                o_mem_addr  = k_addr;
                o_mem_we    = 1'b1;
                o_mem_wdata = i_vx_data;
            end
            StLoad: begin
                o_mem_re   = 1'b1;
                o_mem_addr = k_addr;
                // Read data lags the address by one cycle, so write back V[k-1].
                if (k_q != 4'd0) begin
                    o_vx_en   = 1'b1;
                    o_vx_addr = k_q - 4'd1;
                    o_vx_data = i_mem_rdata;
                end
            end
            StLdrain: begin
                o_vx_en   = 1'b1;
                o_vx_addr = x_q;
                o_vx_data = i_mem_rdata;
            end
            StBcd: begin
                o_vx_addr  = x_q;
                o_mem_addr = k_addr;
                o_mem_we   = 1'b1;
                case (k_q)
                    4'd0:    o_mem_wdata = {4'b0000, dig_hund};
                    4'd1:    o_mem_wdata = {4'b0000, dig_tens};
                    default: o_mem_wdata = {4'b0000, dig_ones};
                endcase
            end
            StFin: begin
                o_done = 1'b1;
                if (INC_I && (op_q == XFER_STORE || op_q == XFER_LOAD)) begin
                    o_i_en   = 1'b1;
                    o_i_data = base_q + MEM_AW'(x_q) + MEM_AW'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Self-checking bench for reg_xfer_ctrl: directed and random transfers against a
// behavioural model of the register file, I and main memory.
module tb_reg_xfer_ctrl;
    import chip8_pkg::*;

    localparam bit INC = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        i_start;
    logic [1:0]  i_op;
    logic [3:0]  i_x;
    logic        o_busy, o_done, o_vx_en, o_i_en, o_mem_we, o_mem_re;
    logic [3:0]  o_vx_addr;
    logic [7:0]  i_vx_data, o_vx_data, o_mem_wdata, i_mem_rdata;
    logic [15:0] i_i_rd, o_i_data, o_mem_addr;

    logic        u0_busy, u0_done, u0_vx_en, u0_i_en, u0_mem_we, u0_mem_re;
    logic [3:0]  u0_vx_addr;
    logic [7:0]  u0_vx_rd, u0_vx_data, u0_mem_wdata;
    logic [15:0] u0_i_data, u0_mem_addr;

    logic [7:0]  mem [0:65535];
    logic [7:0]  vreg [16];
    logic [15:0] ireg;
    logic [7:0]  rdata;

    assign i_i_rd      = ireg;
    assign i_mem_rdata = rdata;
    assign i_vx_data   = vreg[o_vx_addr];
    assign u0_vx_rd    = vreg[u0_vx_addr];

    reg_xfer_ctrl #(.INC_I(INC)) u_dut (
        .clk (clk), .rst (rst), .i_start (i_start), .i_op (i_op), .i_x (i_x),
        .o_busy (o_busy), .o_done (o_done), .o_vx_addr (o_vx_addr), .i_vx_data (i_vx_data),
        .o_vx_en (o_vx_en), .o_vx_data (o_vx_data), .i_i_rd (i_i_rd), .o_i_en (o_i_en),
        .o_i_data (o_i_data), .o_mem_addr (o_mem_addr), .o_mem_we (o_mem_we),
        .o_mem_wdata (o_mem_wdata), .o_mem_re (o_mem_re), .i_mem_rdata (i_mem_rdata)
    );

    reg_xfer_ctrl #(.INC_I(1'b0)) u_dut_noinc (
        .clk (clk), .rst (rst), .i_start (i_start), .i_op (i_op), .i_x (i_x),
        .o_busy (u0_busy), .o_done (u0_done), .o_vx_addr (u0_vx_addr), .i_vx_data (u0_vx_rd),
        .o_vx_en (u0_vx_en), .o_vx_data (u0_vx_data), .i_i_rd (i_i_rd), .o_i_en (u0_i_en),
        .o_i_data (u0_i_data), .o_mem_addr (u0_mem_addr), .o_mem_we (u0_mem_we),
        .o_mem_wdata (u0_mem_wdata), .o_mem_re (u0_mem_re), .i_mem_rdata (i_mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    int busy_n, done_n, done_c, iwr_n, overlap_n, u0_iwr_n, u0_done_n, u0_diff_n;
    int          wr_cyc [$];
    logic [15:0] wr_addr [$];
    int          re_cyc [$];
    int          vx_cyc [$];

    logic        s_we, s_re, s_vx_en, s_i_en;
    logic [15:0] s_addr, s_i_data;
    logic [7:0]  s_wdata, s_vx_data;
    logic [3:0]  s_vx_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs_all();
        return {6'b0, o_busy, o_done, o_vx_addr, o_vx_en, o_vx_data, o_i_en, o_i_data,
                o_mem_addr, o_mem_we, o_mem_wdata, o_mem_re};
    endfunction

    task automatic clear_log();
        busy_n = 0; done_n = 0; done_c = 0; iwr_n = 0; overlap_n = 0;
        u0_iwr_n = 0; u0_done_n = 0; u0_diff_n = 0;
        wr_cyc.delete(); wr_addr.delete(); re_cyc.delete(); vx_cyc.delete();
        s_we = 0; s_re = 0; s_vx_en = 0; s_i_en = 0;
        s_addr = '0; s_i_data = '0; s_wdata = '0; s_vx_data = '0; s_vx_addr = '0;
    endtask

    // Record this cycle's activity; effects land on the next rising edge.
    task automatic sample(input int c);
        busy_n += int'(o_busy);
        if (o_done) begin done_n++; done_c = c; end
        if (o_mem_we) begin wr_cyc.push_back(c); wr_addr.push_back(o_mem_addr); end
        if (o_mem_re) re_cyc.push_back(c);
        if (o_vx_en) vx_cyc.push_back(c);
        if (o_i_en) iwr_n++;
        if (o_i_en && o_vx_en) overlap_n++;
        if (u0_done) u0_done_n++;
        if (u0_i_en) u0_iwr_n++;
        if ({u0_busy, u0_mem_we, u0_mem_re, u0_mem_addr, u0_mem_wdata, u0_vx_en, u0_vx_addr,
             u0_vx_data} !== {o_busy, o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata, o_vx_en,
             o_vx_addr, o_vx_data}) u0_diff_n++;
        s_we = o_mem_we; s_re = o_mem_re; s_addr = o_mem_addr; s_wdata = o_mem_wdata;
        s_vx_en = o_vx_en; s_vx_addr = o_vx_addr; s_vx_data = o_vx_data;
        s_i_en = o_i_en; s_i_data = o_i_data;
    endtask

    task automatic env_apply();
        if (s_we) mem[s_addr] = s_wdata;
        rdata = s_re ? mem[s_addr] : 8'($urandom);
        if (s_vx_en) vreg[s_vx_addr] = s_vx_data;
        if (s_i_en) ireg = s_i_data;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [3:0] x, input bit noisy,
                          input int quiet_from, input int rst_at, input int budget,
                          output bit finished);
        clear_log();
        finished = 1'b0;
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_x = x;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            env_apply();
            @(negedge clk);
            i_start = (noisy && c < quiet_from) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_op = 2'($urandom);
            i_x  = 4'($urandom);
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                chk("async_reset_outputs", outs_all(), 64'd0);
            end
            sample(c);
            if (rst) break;
            if (o_done) begin
                @(posedge clk);
                env_apply();
                s_we = 0; s_re = 0; s_vx_en = 0; s_i_en = 0;
                finished = 1'b1;
                break;
            end
        end
        i_start = 1'b0;
    endtask

    task automatic do_and_check(input string name, input logic [1:0] op, input logic [3:0] x,
                                input bit noisy);
        logic [15:0] base, exp_i;
        logic [7:0]  v_exp [16];
        logic [15:0] ea [$];
        logic [7:0]  eb [$];
        logic [7:0]  v;
        int          exp_len, exp_iwr, exp_rd;
        bit          fin;
        base    = ireg;
        exp_i   = base;
        exp_iwr = 0;
        exp_rd  = 0;
        v_exp   = vreg;
        case (op)
            XFER_STORE: begin
                exp_len = int'(x) + 2;
                for (int k = 0; k <= int'(x); k++) begin
                    ea.push_back(base + 16'(k));
                    eb.push_back(vreg[k]);
                end
            end
            XFER_LOAD: begin
                exp_len = int'(x) + 3;
                exp_rd  = int'(x) + 1;
                for (int k = 0; k <= int'(x); k++) v_exp[k] = mem[base + 16'(k)];
            end
            XFER_BCD: begin
                exp_len = 4;
                v = vreg[x];
                ea.push_back(base);          eb.push_back(v / 8'd100);
                ea.push_back(base + 16'd1);  eb.push_back((v / 8'd10) % 8'd10);
                ea.push_back(base + 16'd2);  eb.push_back(v % 8'd10);
            end
            default: exp_len = 1;
        endcase
        if (INC && (op == XFER_STORE || op == XFER_LOAD)) begin
            exp_i   = base + 16'(x) + 16'd1;
            exp_iwr = 1;
        end

        run_op(op, x, noisy, exp_len, 0, exp_len + 10, fin);

        chk({name, "_finished"}, 64'(fin), 64'd1);
        chk({name, "_done_cycle"}, 64'(done_c), 64'(exp_len));
        chk({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_len));
        chk({name, "_done_pulses"}, 64'(done_n), 64'd1);
        chk({name, "_mem_writes"}, 64'(wr_addr.size()), 64'(ea.size()));
        for (int k = 0; k < ea.size() && k < wr_addr.size(); k++) begin
            chk({name, "_wr_addr"}, 64'(wr_addr[k]), 64'(ea[k]));
            chk({name, "_wr_cycle"}, 64'(wr_cyc[k]), 64'(k + 1));
            chk({name, "_wr_data"}, 64'(mem[ea[k]]), 64'(eb[k]));
        end
        chk({name, "_mem_reads"}, 64'(re_cyc.size()), 64'(exp_rd));
        chk({name, "_vx_writes"}, 64'(vx_cyc.size()), 64'(exp_rd));
        for (int k = 0; k < exp_rd && k < re_cyc.size() && k < vx_cyc.size(); k++) begin
            chk({name, "_rd_cycle"}, 64'(re_cyc[k]), 64'(k + 1));
            chk({name, "_vx_cycle"}, 64'(vx_cyc[k]), 64'(k + 2));
        end
        for (int r = 0; r < 16; r++) chk({name, "_vreg"}, 64'(vreg[r]), 64'(v_exp[r]));
        chk({name, "_i_value"}, 64'(ireg), 64'(exp_i));
        chk({name, "_i_writes"}, 64'(iwr_n), 64'(exp_iwr));
        chk({name, "_v_i_overlap"}, 64'(overlap_n), 64'd0);
        chk({name, "_noinc_same_traffic"}, 64'(u0_diff_n), 64'd0);
        chk({name, "_noinc_i_writes"}, 64'(u0_iwr_n), 64'd0);
        chk({name, "_noinc_done"}, 64'(u0_done_n), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] keep;
        bit         fin;
        i_start = 1'b0; i_op = '0; i_x = '0; rdata = '0; ireg = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int r = 0; r < 16; r++) vreg[r] = '0;
        clear_log();

        #1;
        chk("reset_outputs", outs_all(), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        ireg = 16'h0300;
        for (int r = 0; r < 4; r++) vreg[r] = 8'(11 * (r + 1));
        do_and_check("store_x3", XFER_STORE, 4'd3, 1'b0);
        for (int k = 0; k < 4; k++) chk("store_x3_bytes", 64'(mem[16'h0300 + 16'(k)]), 64'(11 * (k + 1)));
        chk("store_x3_i", 64'(ireg), 64'h0304);

        mem[16'h0400] = 8'hA5; mem[16'h0401] = 8'h5A; mem[16'h0402] = 8'h3C;
        ireg = 16'h0400;
        do_and_check("load_x2", XFER_LOAD, 4'd2, 1'b0);
        chk("load_x2_v0", 64'(vreg[0]), 64'hA5);
        chk("load_x2_v1", 64'(vreg[1]), 64'h5A);
        chk("load_x2_v2", 64'(vreg[2]), 64'h3C);
        chk("load_x2_i", 64'(ireg), 64'h0403);

        ireg = 16'h0500; vreg[5] = 8'd254;
        do_and_check("bcd_254", XFER_BCD, 4'd5, 1'b0);
        chk("bcd_254_digits", 64'({mem[16'h0500], mem[16'h0501], mem[16'h0502]}), 64'h020504);
        chk("bcd_254_i", 64'(ireg), 64'h0500);
        vreg[5] = 8'd0;
        do_and_check("bcd_0", XFER_BCD, 4'd5, 1'b0);
        chk("bcd_0_digits", 64'({mem[16'h0500], mem[16'h0501], mem[16'h0502]}), 64'h000000);
        vreg[5] = 8'd9;
        do_and_check("bcd_9", XFER_BCD, 4'd5, 1'b0);
        chk("bcd_9_digits", 64'({mem[16'h0500], mem[16'h0501], mem[16'h0502]}), 64'h000009);

        ireg = 16'hFFFF; vreg[0] = 8'h12; vreg[1] = 8'h34;
        do_and_check("wrap_store", XFER_STORE, 4'd1, 1'b0);
        chk("wrap_ffff", 64'(mem[16'hFFFF]), 64'h12);
        chk("wrap_0000", 64'(mem[16'h0000]), 64'h34);
        chk("wrap_i", 64'(ireg), 64'h0001);

        ireg = 16'h0600;
        for (int r = 0; r < 16; r++) vreg[r] = 8'($urandom);
        keep = mem[16'h0602];
        run_op(XFER_STORE, 4'd7, 1'b0, 9, 3, 20, fin);
        chk("rst_mid_no_done", 64'(done_n), 64'd0);
        chk("rst_mid_writes", 64'(wr_addr.size()), 64'd2);
        chk("rst_mid_byte0", 64'(mem[16'h0600]), 64'(vreg[0]));
        chk("rst_mid_byte1", 64'(mem[16'h0601]), 64'(vreg[1]));
        chk("rst_mid_byte2_kept", 64'(mem[16'h0602]), 64'(keep));
        chk("rst_mid_i", 64'(ireg), 64'h0600);
        chk("rst_mid_i_writes", 64'(iwr_n), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_and_check("after_reset_bcd", XFER_BCD, 4'd3, 1'b0);

        do_and_check("op3_noisy", 2'd3, 4'd9, 1'b1);
        do_and_check("store_noisy", XFER_STORE, 4'd5, 1'b1);
        do_and_check("load_noisy", XFER_LOAD, 4'd15, 1'b1);

        for (int n = 0; n < 24; n++) begin
            ireg = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ireg = 16'hFFF8 + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                for (int r = 0; r < 16; r++) vreg[r] = 8'($urandom);
            do_and_check("random", 2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_xfer_ctrl.md
# reg_xfer_ctrl

Multi-cycle sequencer for the CHIP-8 bulk register/memory instructions: Fx55 (store V0..Vx at [I]), Fx65 (load V0..Vx from [I]) and Fx33 (BCD of Vx at [I..I+2]). It sits between the instruction decoder and the register file plus main memory. It drives the register file's Vx port and I-write port, and owns the memory port while busy. The decoder issues one start pulse and stalls until done.

## Interface
Parameters:
- INC_I, 1, when 1, Fx55/Fx65 leave I = I + x + 1 (original COSMAC behaviour); when 0, I is untouched.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- i_start  in  1  start request, sampled only in IDLE.
- i_op  in  2  0 = store (Fx55), 1 = load (Fx65), 2 = BCD (Fx33), 3 = reserved.
- i_x  in  4  register index x, captured at start.
- o_busy  out  1  high from the cycle after start acceptance until the done cycle, inclusive.
- o_done  out  1  one-cycle completion pulse.
- o_vx_addr  out  4  register file Vx address; combinational read data comes back on i_vx_data.
- i_vx_data  in  8  register file read data.
- o_vx_en  out  1  register file write enable.
- o_vx_data  out  8  register file write data.
- i_i_rd  in  16  current I.
- o_i_en  out  1  I write enable.
- o_i_data  out  16  new I.
- o_mem_addr  out  16  memory byte address.
- o_mem_we  out  1  memory write strobe.
- o_mem_wdata  out  8  memory write data.
- o_mem_re  out  1  memory read strobe; i_mem_rdata is valid exactly one cycle later.
- i_mem_rdata  in  8  memory read data.

## Operation
- States: IDLE, STORE, LOAD, LDRAIN, BCD, FIN.
- IDLE:
  - i_start=1 latches op, x, base=i_i_rd and k=0.
  - Next state is STORE, LOAD or BCD according to op.
  - Op 3 goes directly to FIN with no side effects.
- STORE:
  - o_vx_addr=k, o_mem_addr=base+k, o_mem_we=1, o_mem_wdata=i_vx_data.
  - k increments each cycle; after k==x, go to FIN.
- LOAD:
  - o_mem_re=1, o_mem_addr=base+k.
  - In each cycle after the first, o_vx_en=1, o_vx_addr=k-1, o_vx_data=i_mem_rdata.
  - After issuing k==x, go to LDRAIN.
- LDRAIN: writes the last returned byte to Vx, then go to FIN.
- BCD:
  - v=Vx is read in the first BCD cycle and held in a register.
  - Three write cycles, in order: [base]=v/100, [base+1]=(v/10)%10, [base+2]=v%10.
  - Each digit is zero-extended to 8 bits. Then go to FIN.
- FIN:
  - o_done=1.
  - If INC_I=1 and op is store or load: o_i_en=1, o_i_data=base+x+1.
  - Next state is IDLE.
- Address arithmetic is 16-bit modulo 2^16: base+k wraps 0xFFFF→0x0000, and so does I.
- i_start is ignored while busy. Inputs other than memory read data and register read data are not sampled after start.
- Every strobe (o_vx_en, o_mem_we, o_mem_re, o_i_en, o_done) is 0 in any state not listed above as driving it.

## Timing
- Reset value: state=IDLE, k=0; all strobes, o_busy and o_done are 0; all address and data outputs are 0.
- Reset mid-operation aborts immediately. Memory bytes already written stay written. I is not updated. No done pulse.
- Start accepted at edge 0. Busy cycle counts:
  - Store: x+2 cycles (x+1 writes, then FIN).
  - Load: x+3 cycles (x+1 reads, drain, FIN).
  - BCD: 4 cycles (3 writes, then FIN).
  - Op 3: 1 cycle.
- i_start may be asserted in the cycle after FIN; back-to-back operations have one IDLE cycle between them.
- The register file write and the I write never occur in the same cycle.

## Structure
- Shared package chip8_pkg holds:
  - Op encodings XFER_STORE=0, XFER_LOAD=1, XFER_BCD=2.
  - The state enum.
  - MEM_AW=16.
- One sub-module, bcd_digits: combinational 8-bit → three 4-bit digits (hundreds, tens, ones).
- The FSM, counter and muxes live in reg_xfer_ctrl.

## Test plan
- Store, x=3, I=0x300, V0..V3=11,22,33,44 → writes 0x300..0x303 on 4 consecutive cycles; FIN sets I=0x304; busy 5 cycles.
- Load, x=2, mem[0x400..0x402]=A,B,C → V0..V2=A,B,C, each written one cycle after its read; I=0x403; busy 5 cycles.
- BCD, V5=254, I=0x500 → mem[0x500..0x502]=2,5,4; I unchanged. Repeat with V5=0 → 0,0,0 and V5=9 → 0,0,9.
- Wrap: store x=1, I=0xFFFF → writes at 0xFFFF then 0x0000; I=0x0001. With INC_I=0, I stays 0xFFFF.
- Reset asserted on the 3rd STORE cycle of x=7 → outputs go to 0 asynchronously, only 2 bytes written, no done, no I write. A new start is accepted after reset release.
- Start pulses during busy, and op=3 → the extra starts are ignored; op 3 gives a done pulse the cycle after start with no memory, V or I activity.
